passage_direction_detector: RTL and testbench

- Sits between the two sonic ranging instances and the occupancy counter/display stage.
- Consumes the two free-running distance registers, sensor A on the outside and sensor B on the inside.
- Applies a hysteresis threshold and debounce to each sensor, then runs a sequence FSM.
- Emits single-cycle enter/exit pulses; the counter only increments or decrements on those pulses and no longer does edge detection itself.

---
 rtl/passage_direction_detector.sv | 244 ++++++++++++++++++++++++
 tb/tb_passage_direction_detector.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/passage_direction_detector.sv
// Passage direction detector: thresholds and debounces two ranging
// distances, then tracks A->B / B->A passages and pulses the result.
//
// Ports:
//   clk50        : 50 MHz system clock
//   rst_n        : asynchronous active-low reset
//   distance_a   : outside sensor distance, cm (33-bit unsigned)
//   distance_b   : inside sensor distance, cm (33-bit unsigned)
//   enter_pulse  : one-cycle pulse on a completed A-to-B passage
//   exit_pulse   : one-cycle pulse on a completed B-to-A passage
//   fault_pulse  : one-cycle pulse on a transit timeout
//   occ_a, occ_b : debounced occupancy flags
//   state        : current sequence state code
module passage_direction_detector #(
  parameter int unsigned SAMPLE_DIV      = 500000,
  parameter int unsigned NEAR_CM         = 80,
  parameter int unsigned FAR_CM          = 90,
  parameter int unsigned DEB_SAMPLES     = 3,
  parameter int unsigned TIMEOUT_SAMPLES = 300
) (
  input  logic        clk50,
  input  logic        rst_n,
  input  logic [32:0] distance_a,
  input  logic [32:0] distance_b,
  output logic        enter_pulse,
  output logic        exit_pulse,
  output logic        fault_pulse,
  output logic        occ_a,
  output logic        occ_b,
  output logic [2:0]  state
);

  localparam int unsigned TW =
    (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned DW = $clog2(DEB_SAMPLES + 1);
  localparam int unsigned OW = $clog2(TIMEOUT_SAMPLES + 1);

  localparam logic [TW-1:0] TICK_RLD = TW'(SAMPLE_DIV - 1);
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_SAMPLES);
  localparam logic [OW-1:0] TO_LAST  = OW'(TIMEOUT_SAMPLES - 1);
  localparam logic [32:0]   NEAR     = 33'(NEAR_CM);
  localparam logic [32:0]   FAR      = 33'(FAR_CM);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_A_ON     = 3'd1,
    S_B_ON     = 3'd2,
    S_CROSS_AB = 3'd3,
    S_CROSS_BA = 3'd4,
    S_WAIT_CLR = 3'd5
  } st_e;

  // ---------------------------------------------------------------
  // Sample tick
  // ---------------------------------------------------------------
  logic [TW-1:0] tick_q;
  logic [TW-1:0] tick_d;
  logic          tick;

  assign tick   = (tick_q == '0);
  assign tick_d = tick ? TICK_RLD : tick_q - TW'(1);

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= TICK_RLD;
    end else begin
      tick_q <= tick_d;
    end
  end

  // ---------------------------------------------------------------
  // Hysteresis classification and debounce, index 0 = A, 1 = B
  // ---------------------------------------------------------------
  logic [1:0]         occ_q;
  logic [1:0]         occ_d;
  logic [1:0][DW-1:0] deb_q;
  logic [1:0][DW-1:0] deb_d;
  logic [1:0]         raw;

  // Inside the hysteresis band the sample echoes the current flag,
  // so it never pushes the debounce counter.
  function automatic logic raw_of(
    input logic [32:0] d,
    input logic        occ
  );
    logic r;
    if (d < NEAR) begin
      r = 1'b1;
    end else if (d >= FAR) begin
      r = 1'b0;
    end else begin
      r = occ;
    end
    return r;
  endfunction

  assign raw[0] = raw_of(distance_a, occ_q[0]);
  assign raw[1] = raw_of(distance_b, occ_q[1]);

  always_comb begin
    occ_d = occ_q;
    deb_d = deb_q;
    if (tick) begin
      for (int i = 0; i < 2; i++) begin
        if (raw[i] != occ_q[i]) begin
          if (deb_q[i] + DW'(1) == DEB_MAX) begin
            occ_d[i] = ~occ_q[i];
            deb_d[i] = '0;
          end else begin
            deb_d[i] = deb_q[i] + DW'(1);
          end
        end else begin
          deb_d[i] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
      deb_q <= '0;
    end else begin
      occ_q <= occ_d;
      deb_q <= deb_d;
    end
  end

  // ---------------------------------------------------------------
  // Sequence FSM (works on the flags as they were before this tick)
  // ---------------------------------------------------------------
  st_e           st_q;
  st_e           st_nrm;
  logic          enter_d;
  logic          exit_d;
  logic          enter_q;
  logic          exit_q;
  logic          fault_q;
  logic [OW-1:0] to_q;
  logic          a;
  logic          b;
  logic          transit;
  logic          timeout;

  assign a = occ_q[0];
  assign b = occ_q[1];

  always_comb begin
    st_nrm  = st_q;
    enter_d = 1'b0;
    exit_d  = 1'b0;
    case (st_q)
      S_IDLE: begin
        unique case (1'b1)
          (a && !b): st_nrm = S_A_ON;
          (!a && b): st_nrm = S_B_ON;
          (a && b):  st_nrm = S_WAIT_CLR;
          default:   st_nrm = S_IDLE;
        endcase
      end
      S_A_ON: begin
        if (b) begin
          st_nrm = S_CROSS_AB;
        end else if (!a) begin
          st_nrm = S_IDLE;
        end
      end
      S_CROSS_AB: begin
        if (!a && !b) begin
          st_nrm  = S_IDLE;
          enter_d = 1'b1;
        end else if (a && !b) begin
          st_nrm = S_A_ON;
        end
      end
      S_B_ON: begin
        if (a) begin
          st_nrm = S_CROSS_BA;
        end else if (!b) begin
          st_nrm = S_IDLE;
        end
      end
      S_CROSS_BA: begin
        if (!a && !b) begin
          st_nrm = S_IDLE;
          exit_d = 1'b1;
        end else if (!a && b) begin
          st_nrm = S_B_ON;
        end
      end
      S_WAIT_CLR: begin
        if (!a && !b) begin
          st_nrm = S_IDLE;
        end
      end
      default: st_nrm = S_IDLE;
    endcase
  end

  assign transit = (st_q == S_A_ON)     || (st_q == S_B_ON) ||
                   (st_q == S_CROSS_AB) || (st_q == S_CROSS_BA);

  // The tick that would make the idle count reach the limit fires
  // the fault instead of incrementing.
  assign timeout = transit && (st_nrm == st_q) && (to_q == TO_LAST);

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= S_IDLE;
      to_q    <= '0;
      enter_q <= 1'b0;
      exit_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      enter_q <= 1'b0;
      exit_q  <= 1'b0;
      fault_q <= 1'b0;
      if (tick) begin
        if (timeout) begin
          st_q    <= S_WAIT_CLR;
          to_q    <= '0;
          fault_q <= 1'b1;
        end else begin
          st_q    <= st_nrm;
          enter_q <= enter_d;
          exit_q  <= exit_d;
          if (!transit || (st_nrm != st_q)) begin
            to_q <= '0;
          end else begin
            to_q <= to_q + OW'(1);
          end
        end
      end
    end
  end

  assign enter_pulse = enter_q;
  assign exit_pulse  = exit_q;
  assign fault_pulse = fault_q;
  assign occ_a       = occ_q[0];
  assign occ_b       = occ_q[1];
  assign state       = st_q;

endmodule

// File: tb/tb_passage_direction_detector.sv
// Bench for passage_direction_detector: per-tick scoreboard of
// expected state, flags and pulses, plus per-scenario pulse counts.
module tb_passage_direction_detector;

  localparam int SD = 4;

  logic        clk50;
  logic        rst_n;
  logic [32:0] dist_a;
  logic [32:0] dist_b;
  logic        enter_pulse;
  logic        exit_pulse;
  logic        fault_pulse;
  logic        occ_a;
  logic        occ_b;
  logic [2:0]  state;

  passage_direction_detector #(
    .SAMPLE_DIV      (SD),
    .NEAR_CM         (80),
    .FAR_CM          (90),
    .DEB_SAMPLES     (2),
    .TIMEOUT_SAMPLES (8)
  ) dut (
    .clk50       (clk50),
    .rst_n       (rst_n),
    .distance_a  (dist_a),
    .distance_b  (dist_b),
    .enter_pulse (enter_pulse),
    .exit_pulse  (exit_pulse),
    .fault_pulse (fault_pulse),
    .occ_a       (occ_a),
    .occ_b       (occ_b),
    .state       (state)
  );

  initial clk50 = 1'b0;
  always #5 clk50 = ~clk50;

  typedef struct packed {
    logic [2:0] st;
    logic       oa;
    logic       ob;
    logic [2:0] p;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_en = 0;
  int   n_ex = 0;
  int   n_ft = 0;
  int   b_en;
  int   b_ex;
  int   b_ft;

  // Entry sequence, one entry per tick (hand-derived, DEB=2).
  localparam int ST_T[16] =
    '{0,0,1,1,1,1,3,3,3,3,3,3,3,3,0,0};
  localparam int OA_T[16] =
    '{0,1,1,1,1,1,1,1,1,0,0,0,0,0,0,0};
  localparam int OB_T[16] =
    '{0,0,0,0,0,1,1,1,1,1,1,1,1,0,0,0};
  localparam int DA[4] = '{50, 50, 200, 200};
  localparam int DB[4] = '{200, 50, 50, 200};

  always @(negedge clk50) begin
    if (enter_pulse) n_en <= n_en + 1;
    if (exit_pulse)  n_ex <= n_ex + 1;
    if (fault_pulse) n_ft <= n_ft + 1;
  end

  task automatic check(input string tag, input int got,
                       input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input int st, input int oa,
                              input int ob, input int p);
    exp_t e;
    e.st = 3'(st);
    e.oa = oa[0];
    e.ob = ob[0];
    e.p  = 3'(p);
    return e;
  endfunction

  // Drive one sample period and compare right after its tick.
  task automatic step(input logic [32:0] a, input logic [32:0] b,
                      input exp_t e);
    exp_t x;
    dist_a = a;
    dist_b = b;
    sb.push_back(e);
    repeat (SD) @(posedge clk50);
    @(negedge clk50);
    x = sb.pop_front();
    check("state", int'(state), int'(x.st));
    check("occ_a", int'(occ_a), int'(x.oa));
    check("occ_b", int'(occ_b), int'(x.ob));
    check("enter", int'(enter_pulse), int'(x.p[0]));
    check("exit", int'(exit_pulse), int'(x.p[1]));
    check("fault", int'(fault_pulse), int'(x.p[2]));
  endtask

  task automatic mark();
    #1;
    b_en = n_en;
    b_ex = n_ex;
    b_ft = n_ft;
  endtask

  task automatic counts(input string tag, input int en,
                        input int ex, input int ft);
    #1;
    check({tag, "_enter_cnt"}, n_en - b_en, en);
    check({tag, "_exit_cnt"}, n_ex - b_ex, ex);
    check({tag, "_fault_cnt"}, n_ft - b_ft, ft);
  endtask

  // mir swaps the sensors: exit sequence instead of entry.
  task automatic entry_seq(input bit mir, input int from,
                           input int to);
    for (int i = from; i < to; i++) begin
      int s;
      int p;
      s = ST_T[i];
      p = (i == 14) ? (mir ? 2 : 1) : 0;
      if (mir && s == 1) s = 2;
      else if (mir && s == 3) s = 4;
      if (mir)
        step(33'(DB[i/4]), 33'(DA[i/4]), mk(s, OB_T[i], OA_T[i], p));
      else
        step(33'(DA[i/4]), 33'(DB[i/4]), mk(s, OA_T[i], OB_T[i], p));
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    dist_a = 33'd200;
    dist_b = 33'd200;
    repeat (3) @(negedge clk50);
    check("rst_state", int'(state), 0);
    check("rst_occ_a", int'(occ_a), 0);
    check("rst_occ_b", int'(occ_b), 0);
    check("rst_pulses", int'({enter_pulse, exit_pulse, fault_pulse}), 0);
    rst_n = 1'b1;

    // Entry
    mark();
    entry_seq(1'b0, 0, 16);
    counts("entry", 1, 0, 0);

    // Exit
    mark();
    entry_seq(1'b1, 0, 16);
    counts("exit", 0, 1, 0);

    // Retreat; clear value above 2^32 must still read as far
    mark();
    step(50, 200, mk(0, 0, 0, 0));
    step(50, 200, mk(0, 1, 0, 0));
    step(50, 200, mk(1, 1, 0, 0));
    step(50, 200, mk(1, 1, 0, 0));
    step(33'h1_0000_0032, 200, mk(1, 1, 0, 0));
    step(33'h1_0000_0032, 200, mk(1, 0, 0, 0));
    step(33'h1_0000_0032, 200, mk(0, 0, 0, 0));
    step(33'h1_0000_0032, 200, mk(0, 0, 0, 0));
    counts("retreat", 0, 0, 0);

    // Alternating raw samples never reach the debounce count
    for (int i = 0; i < 6; i++)
      step((i % 2) ? 33'd200 : 33'd50, 200, mk(0, 0, 0, 0));

    // Hysteresis band edges: 80 and 89 hold, 79 sets, 90 clears
    mark();
    step(85, 200, mk(0, 0, 0, 0));
    step(80, 200, mk(0, 0, 0, 0));
    step(85, 200, mk(0, 0, 0, 0));
    step(79, 200, mk(0, 0, 0, 0));
    step(79, 200, mk(0, 1, 0, 0));
    step(85, 200, mk(1, 1, 0, 0));
    step(89, 200, mk(1, 1, 0, 0));
    step(85, 200, mk(1, 1, 0, 0));
    step(90, 200, mk(1, 1, 0, 0));
    step(90, 200, mk(1, 0, 0, 0));
    step(90, 200, mk(0, 0, 0, 0));
    counts("hyst", 0, 0, 0);

    // Both at once from idle goes straight to WAIT_CLR
    mark();
    step(50, 50, mk(0, 0, 0, 0));
    step(50, 50, mk(0, 1, 1, 0));
    step(50, 50, mk(5, 1, 1, 0));
    step(200, 200, mk(5, 1, 1, 0));
    step(200, 200, mk(5, 0, 0, 0));
    step(200, 200, mk(0, 0, 0, 0));
    counts("both", 0, 0, 0);

    // Timeout: fault on the 8th tick after entering A_ON
    mark();
    step(50, 200, mk(0, 0, 0, 0));
    step(50, 200, mk(0, 1, 0, 0));
    for (int i = 0; i < 8; i++) step(50, 200, mk(1, 1, 0, 0));
    step(50, 200, mk(5, 1, 0, 4));
    for (int i = 0; i < 4; i++) step(50, 200, mk(5, 1, 0, 0));
    step(200, 200, mk(5, 1, 0, 0));
    step(200, 200, mk(5, 0, 0, 0));
    step(200, 200, mk(0, 0, 0, 0));
    counts("timeout", 0, 0, 1);

    // Async reset while in CROSS_AB
    mark();
    entry_seq(1'b0, 0, 8);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_state", int'(state), 0);
    check("arst_occ_a", int'(occ_a), 0);
    check("arst_occ_b", int'(occ_b), 0);
    check("arst_pulses",
          int'({enter_pulse, exit_pulse, fault_pulse}), 0);
    repeat (2) @(negedge clk50);
    rst_n = 1'b1;
    step(200, 50, mk(0, 0, 0, 0));
    step(200, 50, mk(0, 0, 1, 0));
    step(200, 50, mk(2, 0, 1, 0));
    step(200, 50, mk(2, 0, 1, 0));
    step(200, 200, mk(2, 0, 1, 0));
    step(200, 200, mk(2, 0, 0, 0));
    step(200, 200, mk(0, 0, 0, 0));
    step(200, 200, mk(0, 0, 0, 0));
    counts("arst", 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
